// File: rtl/dr_load_sequencer.sv
// rtl/dr_load_sequencer.sv - sequences DR loads from memory reads or ALU writeback
//
// Optional build macro: DR_RR_ARB_EN
//   defined   : round-robin arbitration when both sources request together
//   undefined : fixed priority, ALU wins when both sources request together
//
// Parameters:
//   ADDR_W  - memory address width
//   MEM_LAT - cycles from the mem_rd cycle to valid mem_bus data (1..15)
//
// Ports:
//   clk          - system clock, rising-edge
//   rst_n        - asynchronous active-low reset
//   mem_req      - level request to load DR from memory
//   mem_req_addr - address for mem_req, sampled on accept
//   alu_req      - level request to load DR from the ALU result
//   mem_gnt      - one-cycle pulse, memory request accepted
//   alu_gnt      - one-cycle pulse, ALU request accepted
//   mem_rd       - one-cycle memory read strobe
//   mem_addr     - read address, held from accept until the next accept
//   dr_sel       - DR source select (1 = ALU, 0 = memory bus)
//   dr_ld        - DR load enable
//   busy         - high whenever the sequencer is not idle
//   done         - one-cycle pulse coincident with dr_ld

module dr_load_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic              alu_req,
    output logic              mem_gnt,
    output logic              alu_gnt,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              dr_sel,
    output logic              dr_ld,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU_LD,
        S_MEM_RD,
        S_MEM_WAIT,
        S_MEM_LD
    } state_t;

    // MEM_WAIT lasts MEM_LAT-1 cycles; the counter runs 0..WAIT_TC.
    localparam logic [3:0] WAIT_TC = 4'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;
    logic        take_alu;
    logic        take_mem;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful while idle)
    // ------------------------------------------------------------------
`ifdef DR_RR_ARB_EN
    // 1 = ALU was granted last; reset value makes the first tie go to memory
    logic last_alu;

    always_comb begin
        take_alu = 1'b0;
        take_mem = 1'b0;
        if (state == S_IDLE) begin
            if (alu_req && mem_req) begin
                take_alu = ~last_alu;
                take_mem = last_alu;
            end else begin
                take_alu = alu_req;
                take_mem = mem_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_alu <= 1'b1;
        end else if (take_alu) begin
            last_alu <= 1'b1;
        end else if (take_mem) begin
            last_alu <= 1'b0;
        end
    end
`else
    always_comb begin
        take_alu = 1'b0;
        take_mem = 1'b0;
        if (state == S_IDLE) begin
            take_alu = alu_req;
            take_mem = mem_req & ~alu_req;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (take_alu) begin
                    state_nxt = S_ALU_LD;
                end else if (take_mem) begin
                    state_nxt = S_MEM_RD;
                end
            end
            S_ALU_LD: begin
                state_nxt = S_IDLE;
            end
            S_MEM_RD: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = (MEM_LAT == 1) ? S_MEM_LD : S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (wait_cnt == WAIT_TC) begin
                    state_nxt = S_MEM_LD;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_MEM_LD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next
    // state so they are valid during the cycle the state is occupied.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            mem_gnt  <= 1'b0;
            alu_gnt  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            dr_sel   <= 1'b0;
            dr_ld    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_gnt  <= (state_nxt == S_MEM_RD);
            mem_rd   <= (state_nxt == S_MEM_RD);
            alu_gnt  <= (state_nxt == S_ALU_LD);
            dr_sel   <= (state_nxt == S_ALU_LD);
            dr_ld    <= (state_nxt == S_ALU_LD) || (state_nxt == S_MEM_LD);
            done     <= (state_nxt == S_ALU_LD) || (state_nxt == S_MEM_LD);
            busy     <= (state_nxt != S_IDLE);
            if (take_mem) begin
                mem_addr <= mem_req_addr;
            end
        end
    end

endmodule

// File: tb/tb_dr_load_sequencer.sv
// tb/tb_dr_load_sequencer.sv - self-checking bench for dr_load_sequencer

module tb_dr_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        alu_req = 1'b0;
    logic [15:0] mem_req_addr = 16'h0000;

    logic        mem_gnt_3, alu_gnt_3, mem_rd_3, dr_sel_3, dr_ld_3, busy_3, done_3;
    logic [15:0] mem_addr_3;
    logic        mem_gnt_1, alu_gnt_1, mem_rd_1, dr_sel_1, dr_ld_1, busy_1, done_1;
    logic [15:0] mem_addr_1;

    always #5 clk = ~clk;

    dr_load_sequencer #(.ADDR_W(16), .MEM_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_req_addr(mem_req_addr),
        .alu_req(alu_req), .mem_gnt(mem_gnt_3), .alu_gnt(alu_gnt_3), .mem_rd(mem_rd_3),
        .mem_addr(mem_addr_3), .dr_sel(dr_sel_3), .dr_ld(dr_ld_3), .busy(busy_3),
        .done(done_3)
    );

    dr_load_sequencer #(.ADDR_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_req_addr(mem_req_addr),
        .alu_req(alu_req), .mem_gnt(mem_gnt_1), .alu_gnt(alu_gnt_1), .mem_rd(mem_rd_1),
        .mem_addr(mem_addr_1), .dr_sel(dr_sel_1), .dr_ld(dr_ld_1), .busy(busy_1),
        .done(done_1)
    );

    // Memory and DR model for the MEM_LAT=3 instance: data is on the bus
    // during the cycle MEM_LAT cycles after the mem_rd cycle, DR captures
    // on the falling edge.
    localparam logic [7:0] MEM_BYTE = 8'h5C;
    localparam logic [7:0] ALU_BYTE = 8'hA7;
    logic [3:0] rd_pipe = 4'h0;
    logic [7:0] dr_q = 8'h00;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe = 4'h0;
            dr_q    = 8'h00;
        end else begin
            rd_pipe = {rd_pipe[2:0], mem_rd_3};
            if (dr_ld_3) begin
                dr_q = dr_sel_3 ? ALU_BYTE : (rd_pipe[3] ? MEM_BYTE : 8'h00);
            end
        end
    end

    // output packing: {mem_gnt, alu_gnt, mem_rd, dr_sel, dr_ld, busy, done}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_ALU  = 7'b0101111;
    localparam logic [6:0] O_MRD  = 7'b1010010;
    localparam logic [6:0] O_WAIT = 7'b0000010;
    localparam logic [6:0] O_MLD  = 7'b0000111;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs3();
        return {mem_gnt_3, alu_gnt_3, mem_rd_3, dr_sel_3, dr_ld_3, busy_3, done_3};
    endfunction

    function automatic logic [6:0] outs1();
        return {mem_gnt_1, alu_gnt_1, mem_rd_1, dr_sel_1, dr_ld_1, busy_1, done_1};
    endfunction

    typedef struct {
        logic        mreq;
        logic        areq;
        logic [15:0] addr;
        logic [6:0]  outs;
        logic [15:0] maddr;
        logic [7:0]  dr;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [1:0] g[4];
        logic [1:0] g_exp[4];
        int         got;
        int         first_cyc;
        logic       seen_mem;
        logic       seen_alu;

        // single-source sequence on the MEM_LAT=3 instance
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, O_ALU,  16'h0000, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, O_IDLE, 16'h0000, ALU_BYTE};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, O_IDLE, 16'h0000, ALU_BYTE};
        vecs[3]  = '{1'b1, 1'b0, 16'h1A2B, O_MRD,  16'h1A2B, ALU_BYTE};
        vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, O_WAIT, 16'h1A2B, ALU_BYTE};
        vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, O_WAIT, 16'h1A2B, ALU_BYTE};
        vecs[6]  = '{1'b0, 1'b0, 16'hFFFF, O_MLD,  16'h1A2B, ALU_BYTE};
        vecs[7]  = '{1'b0, 1'b0, 16'hFFFF, O_IDLE, 16'h1A2B, MEM_BYTE};
        vecs[8]  = '{1'b1, 1'b0, 16'h0042, O_MRD,  16'h0042, MEM_BYTE};
        vecs[9]  = '{1'b0, 1'b1, 16'h0042, O_WAIT, 16'h0042, MEM_BYTE};
        vecs[10] = '{1'b0, 1'b1, 16'h0042, O_WAIT, 16'h0042, MEM_BYTE};
        vecs[11] = '{1'b0, 1'b1, 16'h0042, O_MLD,  16'h0042, MEM_BYTE};
        vecs[12] = '{1'b0, 1'b1, 16'h0042, O_IDLE, 16'h0042, MEM_BYTE};
        vecs[13] = '{1'b0, 1'b1, 16'h0042, O_ALU,  16'h0042, MEM_BYTE};
        vecs[14] = '{1'b0, 1'b0, 16'h0042, O_IDLE, 16'h0042, ALU_BYTE};
        vecs[15] = '{1'b1, 1'b0, 16'h00AA, O_MRD,  16'h00AA, ALU_BYTE};
        vecs[16] = '{1'b0, 1'b0, 16'h1234, O_WAIT, 16'h00AA, ALU_BYTE};
        vecs[17] = '{1'b0, 1'b0, 16'h1234, O_WAIT, 16'h00AA, ALU_BYTE};
        vecs[18] = '{1'b0, 1'b0, 16'h1234, O_MLD,  16'h00AA, ALU_BYTE};
        vecs[19] = '{1'b0, 1'b0, 16'h1234, O_IDLE, 16'h00AA, MEM_BYTE};

`ifdef DR_RR_ARB_EN
        g_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // ---- reset held with both requests high ----
        mem_req      = 1'b1;
        alu_req      = 1'b1;
        mem_req_addr = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("reset_outs_lat3", {outs3(), mem_addr_3}, 23'h0);
            chk("reset_outs_lat1", {outs1(), mem_addr_1}, 23'h0);
        end
        #4 rst_n = 1'b1;

        // ---- simultaneous requests held high after release ----
        got       = 0;
        first_cyc = -1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(posedge clk); #1;
            if (mem_gnt_3 || alu_gnt_3) begin
                if (got == 0) first_cyc = c;
                g[got] = {mem_gnt_3, alu_gnt_3};
                got++;
            end
        end
        chk("first_grant_cycle", first_cyc, 0);
        chk("grant_count", got, 4);
        for (int i = 0; i < 4; i++) begin
            chk("grant_order", {30'h0, g[i]}, {30'h0, g_exp[i]});
        end

        // memory is served once the ALU stops asking
        alu_req  = 1'b0;
        seen_mem = 1'b0;
        seen_alu = 1'b0;
        for (int c = 0; c < 20 && !seen_mem; c++) begin
            @(posedge clk); #1;
            if (alu_gnt_3) seen_alu = 1'b1;
            if (mem_gnt_3) seen_mem = 1'b1;
        end
        chk("mem_after_alu_drop", seen_mem, 1'b1);
        chk("no_alu_after_drop", seen_alu, 1'b0);
        chk("mem_addr_on_tie", mem_addr_3, 16'hBEEF);
        mem_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // ---- fresh reset, then table ----
        rst_n = 1'b0;
        #14 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mem_req      = vecs[i].mreq;
            alu_req      = vecs[i].areq;
            mem_req_addr = vecs[i].addr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_outs", i), outs3(), vecs[i].outs);
            chk($sformatf("vec%0d_maddr", i), mem_addr_3, vecs[i].maddr);
            chk($sformatf("vec%0d_dr", i), dr_q, vecs[i].dr);
        end

        // ---- reset in the middle of a memory read ----
        mem_req      = 1'b1;
        mem_req_addr = 16'h7777;
        @(posedge clk); #1;
        chk("midrst_accept", outs3(), O_MRD);
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_wait", outs3(), O_WAIT);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_immediate", {outs3(), mem_addr_3}, 23'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_load", {dr_ld_3, done_3}, 2'b00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_idle_after", {outs3(), mem_addr_3}, 23'h0);
        end
        chk("midrst_dr_untouched", dr_q, 8'h00);

        // ---- MEM_LAT=1 boundary ----
        mem_req      = 1'b1;
        mem_req_addr = 16'h0BEE;
        @(posedge clk); #1;
        chk("lat1_rd", outs1(), O_MRD);
        chk("lat1_addr", mem_addr_1, 16'h0BEE);
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("lat1_ld", outs1(), O_MLD);
        @(posedge clk); #1;
        chk("lat1_idle", outs1(), O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
